// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register bank.
// One winner per arbitration writes its slice; lock allows bounded bursts.
module dff_reg_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [N_REQ-1:0]                          req,
  input  logic [N_REQ-1:0]                          lock,
  input  logic [N_REQ*WIDTH-1:0]                    wdata,
  output logic [N_REQ-1:0]                          grant,
  output logic [N_REQ-1:0]                          ack,
  output logic [WIDTH-1:0]                          q,
  output logic                                      q_vld,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic [N_REQ-1:0]    ack_nxt;
  logic [WIDTH-1:0]    q_nxt;
  logic                q_vld_nxt;
  logic [IDX_W-1:0]    owner_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [IDX_W-1:0]    gidx, gidx_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;

  // Rotating priority scan starting just after the last granted index.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!win_vld && req[IDX_W'((32'(ptr) + i) % N_REQ)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((32'(ptr) + i) % N_REQ);
      end
    end
  end

  // State and datapath registers; reset drops any in-flight write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ack      <= '0;
      q        <= '0;
      q_vld    <= 1'b0;
      owner    <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
      gidx     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ack      <= ack_nxt;
      q        <= q_nxt;
      q_vld    <= q_vld_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ack_nxt   = '0;
    q_nxt     = q;
    q_vld_nxt = q_vld;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    hold_nxt  = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (win_vld) begin
          grant_nxt = N_REQ'(1) << win_idx;
          gidx_nxt  = win_idx;
          hold_nxt  = HOLD_W'(1);
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!req[gidx]) begin
          grant_nxt = '0;
          ptr_nxt   = gidx;
          state_nxt = ST_IDLE;
        end else begin
          q_nxt     = wdata[32'(gidx) * WIDTH +: WIDTH];
          ack_nxt   = N_REQ'(1) << gidx;
          q_vld_nxt = 1'b1;
          owner_nxt = gidx;
          if (lock[gidx] && (hold_cnt < HOLD_W'(MAX_HOLD))) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end else begin
            grant_nxt = '0;
            ptr_nxt   = gidx;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter: reset, rotation, locked burst,
// abort and asynchronous reset, checked against hand-computed values.
module tb_dff_reg_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   CLK;
  logic                   RST;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   q_vld;
  logic [1:0]             owner;

  int n_tests = 0;
  int n_fail  = 0;

  dff_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .CLK(CLK), .RST(RST), .req(req), .lock(lock), .wdata(wdata),
    .grant(grant), .ack(ack), .q(q), .q_vld(q_vld), .owner(owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [7:0] val);
    wdata[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    RST = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    RST = 1'b0; req = 4'b1111; lock = 4'b1111; wdata = '1;
    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_ack",   32'(ack),   32'h0);
    check("reset_q",     32'(q),     32'h0);
    check("reset_qvld",  32'(q_vld), 32'h0);
    check("reset_owner", 32'(owner), 32'h0);
    req = '0; lock = '0; wdata = '0;
    #4 RST = 1'b1;
    step();

    // Single requester
    req = 4'b0001; set_slice(0, 8'hA5);
    step();
    check("single_grant", 32'(grant), 32'h1);
    check("single_ack_early", 32'(ack), 32'h0);
    step();
    req = 4'b0000;
    check("single_q",     32'(q),     32'hA5);
    check("single_ack",   32'(ack),   32'h1);
    check("single_qvld",  32'(q_vld), 32'h1);
    check("single_owner", 32'(owner), 32'h0);
    check("single_gdrop", 32'(grant), 32'h0);
    step();
    check("single_ack_pulse", 32'(ack), 32'h0);
    check("single_q_hold", 32'(q), 32'hA5);

    // Full rotation, all requesting, no lock
    do_reset();
    for (int i = 0; i < 4; i++) set_slice(i, vals[i]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant", 32'(grant), 32'(1) << order[k]);
      step();
      if (k == 4) req = 4'b0000;
      check("rr_q",     32'(q),     32'(vals[order[k]]));
      check("rr_ack",   32'(ack),   32'(1) << order[k]);
      check("rr_owner", 32'(owner), 32'(order[k]));
    end

    // Locked burst bounded by MAX_HOLD
    do_reset();
    set_slice(0, 8'h0A); set_slice(1, 8'hB0);
    req = 4'b0011; lock = 4'b0010;
    step();
    check("lk_grant0", 32'(grant), 32'h1);
    step();
    check("lk_ack0", 32'(ack), 32'h1);
    check("lk_q0",   32'(q),   32'h0A);
    step();
    check("lk_grant1", 32'(grant), 32'h2);
    for (int b = 0; b < 4; b++) begin
      set_slice(1, 8'(8'hB0 + b));
      step();
      check("lk_burst_ack", 32'(ack), 32'h2);
      check("lk_burst_q",   32'(q),   32'(8'hB0 + b));
      check("lk_burst_grant", 32'(grant), (b == 3) ? 32'h0 : 32'h2);
    end
    step();
    check("lk_next_grant", 32'(grant), 32'h1);
    check("lk_gap_ack", 32'(ack), 32'h0);
    step();
    req = 4'b0000; lock = 4'b0000;
    check("lk_next_ack", 32'(ack), 32'h1);
    check("lk_next_q",   32'(q),   32'h0A);

    // Abort: requester 2 drops during WRITE, 3 wins next
    set_slice(2, 8'hEE); set_slice(3, 8'h3C); set_slice(0, 8'h5A);
    req = 4'b0100;
    step();
    check("ab_grant2", 32'(grant), 32'h4);
    req = 4'b1001;
    step();
    check("ab_noack", 32'(ack),   32'h0);
    check("ab_q",     32'(q),     32'h0A);
    check("ab_grant", 32'(grant), 32'h0);
    step();
    check("ab_win3", 32'(grant), 32'h8);
    step();
    req = 4'b0000;
    check("ab_q3",   32'(q),   32'h3C);
    check("ab_ack3", 32'(ack), 32'h8);
    // Abort again with only requester 0 waiting: 0 wins
    req = 4'b0100;
    step();
    check("ab2_grant2", 32'(grant), 32'h4);
    req = 4'b0001;
    step();
    check("ab2_noack", 32'(ack), 32'h0);
    check("ab2_q",     32'(q),   32'h3C);
    step();
    check("ab2_win0", 32'(grant), 32'h1);
    step();
    req = 4'b0000;
    check("ab2_q0",    32'(q),     32'h5A);
    check("ab2_owner", 32'(owner), 32'h0);

    // Asynchronous reset in the middle of a locked burst
    set_slice(1, 8'h77);
    req = 4'b0010; lock = 4'b0010;
    step();
    check("ar_grant1", 32'(grant), 32'h2);
    step();
    check("ar_q", 32'(q), 32'h77);
    #2 RST = 1'b0;
    #1;
    check("ar_grant0", 32'(grant), 32'h0);
    check("ar_q0",     32'(q),     32'h0);
    check("ar_ack0",   32'(ack),   32'h0);
    check("ar_qvld0",  32'(q_vld), 32'h0);
    RST = 1'b1;
    req = 4'b1111; lock = 4'b0000; set_slice(0, 8'hC3);
    step();
    check("ar_first0", 32'(grant), 32'h1);
    step();
    req = 4'b0000;
    check("ar_ackq", 32'(q), 32'hC3);
    check("ar_owner", 32'(owner), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
